// File: rtl/mem_port2_arbiter.sv
// Round-robin arbiter sharing memory port 2 between the CPU data path and the loader/DMA.
// Optional MEM_ARB_COLLISION_STALL_EN: stall port-2 accesses colliding with port 1.
module mem_port2_arbiter #(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              err0,
    output logic              err1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              p1_read,
    input  logic              p1_write,
    output logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] W2,
    output logic              Write2,
    output logic              Read2,
    input  logic [DATA_W-1:0] R2
);

    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_DEPTH);

    state_t state, state_n;

    logic              last;
    logic              id_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err0_q, err1_q;
    logic              rv0_q, rv1_q;

    logic              win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_rng;
    logic              cap;
    logic              issue;
    logic              stall;
    logic              go;

    // A tie goes to the requester that was not served last
    always_comb begin
        win       = req1 && (!req0 || !last);
        sel_we    = win ? we1 : we0;
        sel_addr  = win ? addr1 : addr0;
        sel_wdata = win ? wdata1 : wdata0;
        in_rng    = {1'b0, sel_addr} < LIMIT;
        // a requester still holds req during its err cycle
        cap       = (state == IDLE) && (req0 || req1) && !(err0_q || err1_q);
    end

    assign issue = (state == ISSUE);

`ifdef MEM_ARB_COLLISION_STALL_EN
    assign stall = issue && (addr_q == p1_addr) &&
                   ((we_q && (p1_read || p1_write)) || (!we_q && p1_write));
`else
    logic unused_p1;
    assign unused_p1 = ^{p1_addr, p1_read, p1_write};
    assign stall     = 1'b0;
`endif

    assign go      = issue && !stall;
    assign gnt0    = go && !id_q;
    assign gnt1    = go && id_q;
    assign Write2  = go && we_q;
    assign Read2   = go && !we_q;
    assign A2      = addr_q;
    assign W2      = wdata_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rvalid0 = rv0_q;
    assign rvalid1 = rv1_q;
    assign rdata   = R2;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (cap && in_rng) state_n = ISSUE;
            ISSUE:   if (!stall) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last    <= 1'b1;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            err0_q <= cap && !in_rng && !win;
            err1_q <= cap && !in_rng && win;
            rv0_q  <= go && !we_q && !id_q;
            rv1_q  <= go && !we_q && id_q;
            if (cap) begin
                id_q <= win;
                // rejected requests leave A2/W2 showing the last real access
                if (in_rng) begin
                    we_q    <= sel_we;
                    addr_q  <= sel_addr;
                    wdata_q <= sel_wdata;
                end else begin
                    last <= win;
                end
            end
            if (go) last <= id_q;
        end
    end

endmodule

// File: tb/tb_mem_port2_arbiter.sv
// Testbench for mem_port2_arbiter: memory model on port 2 plus a
// transaction-level round-robin reference model.
module tb_mem_port2_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, err0, err1, rvalid0, rvalid1;
    logic [15:0] rdata;
    logic [15:0] p1_addr;
    logic        p1_read, p1_write;
    logic [15:0] A2, W2, R2;
    logic        Write2, Read2;

    logic        pre_we;
    logic [9:0]  pre_a;
    logic [15:0] pre_d;
    logic [15:0] mem [0:1023];
    logic [15:0] ref_mem [0:1023];

    int n_cmp, n_bad, last_srv;

    logic        v [2];
    logic        vwe [2];
    logic [15:0] va [2];
    logic [15:0] vd [2];
    int          xg [2], xe [2], xr [2];
    logic [15:0] xd [2];
    int          gc [2], ec [2], rc [2], ev [2];
    logic [15:0] rd [2];
    int          both, r2c, w2c, r2f, w2f;

    mem_port2_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .p1_addr(p1_addr), .p1_read(p1_read), .p1_write(p1_write),
        .A2(A2), .W2(W2), .Write2(Write2), .Read2(Read2), .R2(R2)
    );

    always #5 clk = ~clk;

    // Port-2 memory: synchronous write, registered read
    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (Write2) mem[A2[9:0]] <= W2;
        if (Read2) R2 <= mem[A2[9:0]];
    end

    task automatic preload(input int a, input logic [15:0] d);
        pre_a = 10'(a);
        pre_d = d;
        pre_we = 1'b1;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    // Reference: winner served first (event at cycle 1), the other at cycle 3
    task automatic predict();
        int f, i, t;
        f = (v[0] && v[1]) ? (last_srv == 1 ? 0 : 1) : (v[1] ? 1 : 0);
        for (int k = 0; k < 2; k++) begin
            i = (k == 0) ? f : 1 - f;
            t = 1 + 2 * k;
            xg[i] = -1; xe[i] = -1; xr[i] = -1; xd[i] = '0;
            if (v[i]) begin
                if (va[i] < 16'd1024) begin
                    xg[i] = t;
                    if (vwe[i]) ref_mem[va[i][9:0]] = vd[i];
                    else begin
                        xr[i] = t + 1;
                        xd[i] = ref_mem[va[i][9:0]];
                    end
                end else begin
                    xe[i] = t;
                end
                last_srv = i;
            end
        end
    endtask

    task automatic run_pair();
        logic pd [2];
        for (int i = 0; i < 2; i++) begin
            gc[i] = -1; ec[i] = -1; rc[i] = -1; ev[i] = 0;
            rd[i] = '0; pd[i] = 1'b0;
        end
        both = 0; r2c = 0; w2c = 0; r2f = -1; w2f = -1;
        req0 = v[0]; we0 = vwe[0]; addr0 = va[0]; wdata0 = vd[0];
        req1 = v[1]; we1 = vwe[1]; addr1 = va[1]; wdata1 = vd[1];
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (pd[0]) req0 = 1'b0;
            if (pd[1]) req1 = 1'b0;
            pd[0] = gnt0 || err0;
            pd[1] = gnt1 || err1;
            if (gnt0) begin ev[0]++; if (gc[0] < 0) gc[0] = c; end
            if (gnt1) begin ev[1]++; if (gc[1] < 0) gc[1] = c; end
            if (err0) begin ev[0]++; if (ec[0] < 0) ec[0] = c; end
            if (err1) begin ev[1]++; if (ec[1] < 0) ec[1] = c; end
            if (rvalid0) begin
                ev[0]++;
                if (rc[0] < 0) begin rc[0] = c; rd[0] = rdata; end
            end
            if (rvalid1) begin
                ev[1]++;
                if (rc[1] < 0) begin rc[1] = c; rd[1] = rdata; end
            end
            if ((gnt0 && gnt1) || (err0 && err1) || (rvalid0 && rvalid1)) both++;
            if (Read2) begin r2c++; if (r2f < 0) r2f = c; end
            if (Write2) begin w2c++; if (w2f < 0) w2f = c; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({gnt0, gnt1, err0, err1, rvalid0, rvalid1, Write2, Read2} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_pulses: got %b want 00000000",
                {gnt0, gnt1, err0, err1, rvalid0, rvalid1, Write2, Read2});
        end
        n_cmp++;
        if ({A2, W2} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_a2w2: got %h/%h want 0/0", A2, W2);
        end
        for (int i = 0; i < 32; i++) preload(i, 16'($urandom));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({gnt0, gnt1, Write2, Read2} !== 4'h0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %b want 0000", {gnt0, gnt1, Write2, Read2});
        end
    endtask

    task automatic test_tie();
        for (int r = 0; r < 2; r++) begin
            v[0] = 1'b1; v[1] = 1'b1; vwe[0] = 1'b1; vwe[1] = 1'b1;
            va[0] = 16'(8 + 2 * r); va[1] = 16'(9 + 2 * r);
            vd[0] = 16'($urandom); vd[1] = 16'($urandom);
            predict();
            run_pair();
            n_cmp++;
            if (gc[0] !== 1) begin
                n_bad++;
                $display("FAIL tie%0d_gnt0: got %0d want 1", r, gc[0]);
            end
            n_cmp++;
            if (gc[1] !== 3) begin
                n_bad++;
                $display("FAIL tie%0d_gnt1: got %0d want 3", r, gc[1]);
            end
            n_cmp++;
            if (w2c !== 2) begin
                n_bad++;
                $display("FAIL tie%0d_write2: got %0d want 2", r, w2c);
            end
        end
    endtask

    task automatic test_single_read();
        preload(5, 16'h1234);
        v[0] = 1'b1; v[1] = 1'b0; vwe[0] = 1'b0; va[0] = 16'h0005; vd[0] = '0;
        vwe[1] = 1'b0; va[1] = '0; vd[1] = '0;
        predict();
        run_pair();
        n_cmp++;
        if (gc[0] !== 1) begin
            n_bad++;
            $display("FAIL read_gnt0: got %0d want 1", gc[0]);
        end
        n_cmp++;
        if (rc[0] !== 2 || rd[0] !== 16'h1234) begin
            n_bad++;
            $display("FAIL read_rvalid: got cyc %0d data %h want cyc 2 data 1234", rc[0], rd[0]);
        end
        n_cmp++;
        if (r2c !== 1 || r2f !== 1) begin
            n_bad++;
            $display("FAIL read_read2: got %0d pulses at %0d want 1 at 1", r2c, r2f);
        end
    endtask

    task automatic test_range();
        v[0] = 1'b0; v[1] = 1'b1; vwe[1] = 1'($urandom); va[1] = 16'h0400;
        vd[1] = 16'($urandom);
        predict();
        run_pair();
        n_cmp++;
        if (ec[1] !== 1 || gc[1] !== -1) begin
            n_bad++;
            $display("FAIL range_err1: got err %0d gnt %0d want err 1 gnt -1", ec[1], gc[1]);
        end
        n_cmp++;
        if (r2c + w2c !== 0 || ev[1] !== 1) begin
            n_bad++;
            $display("FAIL range_strobes: got %0d strobes %0d events want 0 and 1",
                r2c + w2c, ev[1]);
        end
        vwe[1] = 1'b1; va[1] = 16'h000c; vd[1] = 16'($urandom);
        predict();
        run_pair();
        n_cmp++;
        if (gc[1] !== 1 || w2c !== 1) begin
            n_bad++;
            $display("FAIL range_next: got gnt %0d write2 %0d want 1 and 1", gc[1], w2c);
        end
    endtask

    task automatic test_collision();
        logic [15:0] wd;
        int          gcy, wc, wf, want;
        logic        pg;
`ifdef MEM_ARB_COLLISION_STALL_EN
        want = 4;
`else
        want = 1;
`endif
        wd = 16'($urandom);
        gcy = -1; wc = 0; wf = -1; pg = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = wd;
        p1_addr = 16'h0010; p1_write = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 4) p1_write = 1'b0;
            if (pg) req0 = 1'b0;
            pg = gnt0;
            if (gnt0 && gcy < 0) gcy = c;
            if (Write2) begin wc++; if (wf < 0) wf = c; end
        end
        req0 = 1'b0;
        ref_mem[16] = wd;
        last_srv = 0;
        n_cmp++;
        if (gcy !== want) begin
            n_bad++;
            $display("FAIL coll_gnt0: got %0d want %0d", gcy, want);
        end
        n_cmp++;
        if (wc !== 1 || wf !== want) begin
            n_bad++;
            $display("FAIL coll_write2: got %0d pulses at %0d want 1 at %0d", wc, wf, want);
        end
        n_cmp++;
        if (mem[16] !== wd) begin
            n_bad++;
            $display("FAIL coll_mem: got %h want %h", mem[16], wd);
        end
    endtask

    task automatic test_back_to_back();
        int          gcy [3], rcy [3];
        logic [15:0] rdv [3];
        int          ng, nr;
        logic        pg;
        ng = 0; nr = 0; pg = 1'b0;
        for (int k = 0; k < 3; k++) begin gcy[k] = -1; rcy[k] = -1; rdv[k] = '0; end
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0005;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (pg) begin
                if (ng == 3) req0 = 1'b0;
                else addr0 = 16'(5 + ng);
            end
            pg = gnt0;
            if (gnt0) begin if (ng < 3) gcy[ng] = c; ng++; end
            if (rvalid0) begin
                if (nr < 3) begin rcy[nr] = c; rdv[nr] = rdata; end
                nr++;
            end
        end
        req0 = 1'b0;
        last_srv = 0;
        n_cmp++;
        if (ng !== 3 || nr !== 3) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d gnt %0d rvalid want 3 and 3", ng, nr);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (gcy[k] !== 1 + 2 * k || rcy[k] !== 2 + 2 * k) begin
                n_bad++;
                $display("FAIL b2b_timing%0d: got gnt %0d rvalid %0d want %0d and %0d",
                    k, gcy[k], rcy[k], 1 + 2 * k, 2 + 2 * k);
            end
            n_cmp++;
            if (rdv[k] !== ref_mem[5 + k]) begin
                n_bad++;
                $display("FAIL b2b_data%0d: got %h want %h", k, rdv[k], ref_mem[5 + k]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            v[0] = 1'($urandom_range(0, 1));
            v[1] = v[0] ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int i = 0; i < 2; i++) begin
                vwe[i] = 1'($urandom_range(0, 1));
                va[i] = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(1024, 65535))
                                                    : 16'($urandom_range(0, 31));
                vd[i] = 16'($urandom);
            end
            predict();
            run_pair();
            n_cmp++;
            if (both !== 0) begin
                n_bad++;
                $display("FAIL rnd%0d_overlap: got %0d want 0", n, both);
            end
            for (int i = 0; i < 2; i++) begin
                if (v[i]) begin
                    n_cmp++;
                    if (gc[i] !== xg[i] || ec[i] !== xe[i] || rc[i] !== xr[i]) begin
                        n_bad++;
                        $display("FAIL rnd%0d_req%0d_timing: got g%0d e%0d r%0d want g%0d e%0d r%0d",
                            n, i, gc[i], ec[i], rc[i], xg[i], xe[i], xr[i]);
                    end
                    n_cmp++;
                    if (ev[i] !== (xg[i] >= 0 ? 1 : 0) + (xe[i] >= 0 ? 1 : 0) + (xr[i] >= 0 ? 1 : 0)) begin
                        n_bad++;
                        $display("FAIL rnd%0d_req%0d_events: got %0d", n, i, ev[i]);
                    end
                    if (xr[i] >= 0) begin
                        n_cmp++;
                        if (rd[i] !== xd[i]) begin
                            n_bad++;
                            $display("FAIL rnd%0d_req%0d_rdata: got %h want %h", n, i, rd[i], xd[i]);
                        end
                    end
                end else begin
                    n_cmp++;
                    if (ev[i] !== 0) begin
                        n_bad++;
                        $display("FAIL rnd%0d_req%0d_idle: got %0d events want 0", n, i, ev[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int cnt;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0003;
        @(posedge clk);
        #1;
        n_cmp++;
        if (Read2 !== 1'b1 || gnt0 !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_issue: got read2 %b gnt0 %b want 1 1", Read2, gnt0);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gnt0, rvalid0, Read2, Write2} !== 4'h0 || A2 !== 16'h0) begin
            n_bad++;
            $display("FAIL midrst_clear: got %b A2 %h want 0000 A2 0000",
                {gnt0, rvalid0, Read2, Write2}, A2);
        end
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (rvalid0 || gnt0) cnt++;
        end
        last_srv = 1;
        n_cmp++;
        if (cnt !== 0) begin
            n_bad++;
            $display("FAIL midrst_replay: got %0d pulses want 0", cnt);
        end
        v[0] = 1'b1; v[1] = 1'b0; vwe[0] = 1'b0; va[0] = 16'h0003;
        predict();
        run_pair();
        n_cmp++;
        if (rc[0] !== 2 || rd[0] !== xd[0]) begin
            n_bad++;
            $display("FAIL midrst_after: got cyc %0d data %h want cyc 2 data %h", rc[0], rd[0], xd[0]);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; last_srv = 1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        p1_addr = '0; p1_read = 1'b0; p1_write = 1'b0;
        pre_we = 1'b0; pre_a = '0; pre_d = '0;
        test_reset();
        test_tie();
        test_single_read();
        test_range();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
